uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NUM_REQ independent byte sources.
- Round-robin arbitration between requesters.
- Per requester: a valid/ack handshake and a completion pulse.
- Owns the TX launch handshake: drives the serializer's data-valid pulse and byte, monitors its active and done outputs, and runs a watchdog for a hung serializer.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CLKS_PER_BIT, 217, serializer bit period in clocks; only used to derive the timeout.
- TIMEOUT_CLKS, CLKS_PER_BIT*12 (2604), max WAIT_DONE cycles before aborting.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  NUM_REQ  per-requester byte-pending flag; held until ack.
- i_req_byte  in  8*NUM_REQ  flattened bytes; requester n at [8n+7:8n]; stable while valid.
- o_req_ack  out  NUM_REQ  one-hot, one-cycle pulse; byte n consumed.
- o_req_done  out  NUM_REQ  one-hot, one-cycle pulse; byte n finished (stop bit sent).
- o_tx_dv  out  1  one-cycle launch pulse to the serializer.
- o_tx_byte  out  8  byte to the serializer; held until the next launch.
- i_tx_active  in  1  serializer busy.
- i_tx_done  in  1  serializer one-cycle completion pulse.
- o_busy  out  1  high whenever state != IDLE.
- o_err  out  1  one-cycle pulse on watchdog timeout.
- o_owner  out  $clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Reset (i_rst sampled high at posedge) returns all state to reset values from the next cycle. This applies even mid-transfer; no done pulse is issued for an aborted byte.
  - Reset values: state=IDLE; o_req_ack=0, o_req_done=0, o_tx_dv=0, o_tx_byte=0, o_busy=0, o_err=0.
  - o_owner=NUM_REQ-1, so requester 0 wins first. Timeout counter=0.
- States: IDLE, WAIT_ACTIVE, WAIT_DONE, GAP.
- IDLE:
  - If any i_req_valid and i_tx_active==0, choose winner g = first set valid bit searching o_owner+1, o_owner+2, ... with modulo NUM_REQ wrap.
  - Registered at the next edge: o_tx_byte<=byte[g]; o_tx_dv<=1; o_req_ack<=onehot(g); o_owner<=g; counter<=0; state<=WAIT_ACTIVE.
  - Latency is 1 cycle from valid sampled to ack/dv.
  - If i_tx_active==1, remain in IDLE with no grant.
- WAIT_ACTIVE:
  - o_tx_dv and o_req_ack are already back to 0; counter increments.
  - On i_tx_active==1, go to WAIT_DONE.
  - If i_tx_done arrives directly, treat it as in WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - On i_tx_done==1: o_req_done<=onehot(o_owner), state<=GAP.
- Timeout (WAIT_ACTIVE or WAIT_DONE): when counter reaches TIMEOUT_CLKS-1 without done, o_err<=1 for one cycle, no o_req_done, state<=GAP.
  - If done and timeout occur in the same cycle, done wins and there is no err.
- GAP: exactly one cycle, then IDLE. This guarantees at least one idle line cycle between bytes.
- Fairness:
  - A requester that was just served has lowest priority next round.
  - With all NUM_REQ valid continuously, grants cycle 0,1,2,3,0,...
- Requesters that deassert valid before ack are simply skipped; no ack is issued to them.
- The counter saturates; it never wraps.
- o_busy = (state != IDLE), combinational from the state register.

Test Plan:
- Reset, then requester 2 valid with byte 8'h37, using the real serializer at CLKS_PER_BIT=217 and 40 ns clock:
  - o_req_ack=4'b0100 and o_tx_dv both pulse exactly 1 cycle after valid.
  - o_tx_byte=8'h37; line decodes 0x37.
  - o_req_done=4'b0100 ~2170 clocks later; o_owner=2.
- All four requesters valid with 8'h10/11/12/13 held until each ack:
  - Serial order 0x10, 0x11, 0x12, 0x13.
  - Acks 0001, 0010, 0100, 1000; each done precedes the next ack by >=2 cycles (GAP).
- Requester 1 served, then requesters 1 and 3 valid simultaneously: requester 3 is granted before 1.
- Serializer model that never asserts i_tx_done, TIMEOUT_CLKS=50:
  - o_err pulses exactly 50 cycles after dv; no o_req_done.
  - The next pending request is granted normally.
- i_rst asserted 500 cycles into a byte:
  - Next cycle o_busy=0, o_tx_dv=0, o_owner=3, and no done pulse is issued.
  - A new request then gets ack on requester 0 first.
- i_tx_active held high externally while requester 0 is valid:
  - No ack, o_busy=0.
  - Ack 1 cycle after i_tx_active falls.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer signals shared by uart_tx_arbiter and its environment.
// The master modport is the arbiter's view; slave is the requester/serializer side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned OWNER_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_req_valid;
    logic [8*NUM_REQ-1:0] i_req_byte;
    logic [NUM_REQ-1:0]   o_req_ack;
    logic [NUM_REQ-1:0]   o_req_done;
    logic                 o_tx_dv;
    logic [7:0]           o_tx_byte;
    logic                 i_tx_active;
    logic                 i_tx_done;
    logic                 o_busy;
    logic                 o_err;
    logic [OWNER_W-1:0]   o_owner;

    modport master (
        input  i_req_valid, i_req_byte, i_tx_active, i_tx_done,
        output o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_err, o_owner
    );

    modport slave (
        output i_req_valid, i_req_byte, i_tx_active, i_tx_done,
        input  o_req_ack, o_req_done, o_tx_dv, o_tx_byte, o_busy, o_err, o_owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NUM_REQ byte sources,
// with a launch handshake, per-requester completion pulses and a hang watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned OWNER_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACTIVE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   req_done;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 err;
    logic [OWNER_W-1:0]   owner;
    logic [CNT_W-1:0]     cnt;

    logic                 grant_any;
    logic [OWNER_W-1:0]   grant_idx;
    logic [OWNER_W-1:0]   cand;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Search starts just after the last owner, so the previous winner is checked last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = owner;
        cand      = owner;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = OWNER_W'((32'(owner) + k) % NUM_REQ);
            if (!grant_any && bus.i_req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            req_ack  <= '0;
            req_done <= '0;
            tx_dv    <= 1'b0;
            tx_byte  <= '0;
            err      <= 1'b0;
            owner    <= OWNER_W'(NUM_REQ - 1);
            cnt      <= '0;
        end else begin
            req_ack  <= '0;
            req_done <= '0;
            tx_dv    <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any && !bus.i_tx_active) begin
                        tx_byte <= bus.i_req_byte[{grant_idx, 3'b000} +: 8];
                        tx_dv   <= 1'b1;
                        req_ack <= onehot(grant_idx);
                        owner   <= grant_idx;
                        cnt     <= '0;
                        state   <= WAIT_ACTIVE;
                    end
                end
                WAIT_ACTIVE, WAIT_DONE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                    // A done seen in the timeout cycle still counts as success.
                    if (bus.i_tx_done) begin
                        req_done <= onehot(owner);
                        state    <= GAP;
                    end else if (cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        state <= GAP;
                    end else if (state == WAIT_ACTIVE && bus.i_tx_active) begin
                        state <= WAIT_DONE;
                    end
                end
                GAP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ack  = req_ack;
    assign bus.o_req_done = req_done;
    assign bus.o_tx_dv    = tx_dv;
    assign bus.o_tx_byte  = tx_byte;
    assign bus.o_err      = err;
    assign bus.o_owner    = owner;
    assign bus.o_busy     = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a full-rate UART serializer model with line decoder on
// one instance, a hung serializer with a short timeout on a second instance.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned CPB  = 217;
    localparam int unsigned TO_B = 50;

    localparam int K_ACK  = 0;
    localparam int K_LINE = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic model_rst = 1'b1;
    logic ext_active = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus_a ();
    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus_b ();

    uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );
    uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );

    // Serializer model: start bit, 8 data bits LSB first, stop bit, then a done pulse.
    int         ser_st = 0;
    int         ser_cnt = 0;
    int         ser_bi = 0;
    logic [7:0] ser_sh = '0;
    logic       ser_line = 1'b1;
    logic       ser_active = 1'b0;
    logic       ser_done = 1'b0;

    always @(posedge clk) begin
        if (model_rst) begin
            ser_st <= 0; ser_cnt <= 0; ser_line <= 1'b1; ser_active <= 1'b0; ser_done <= 1'b0;
        end else begin
            ser_done <= 1'b0;
            case (ser_st)
                0: if (bus_a.o_tx_dv) begin
                    ser_sh <= bus_a.o_tx_byte; ser_line <= 1'b0; ser_active <= 1'b1;
                    ser_cnt <= 0; ser_st <= 1;
                end
                1: if (ser_cnt == CPB - 1) begin
                    ser_cnt <= 0; ser_line <= ser_sh[0]; ser_bi <= 0; ser_st <= 2;
                end else ser_cnt <= ser_cnt + 1;
                2: if (ser_cnt == CPB - 1) begin
                    ser_cnt <= 0;
                    if (ser_bi == 7) begin
                        ser_line <= 1'b1; ser_st <= 3;
                    end else begin
                        ser_line <= ser_sh[ser_bi + 1]; ser_bi <= ser_bi + 1;
                    end
                end else ser_cnt <= ser_cnt + 1;
                default: if (ser_cnt == CPB - 1) begin
                    ser_cnt <= 0; ser_done <= 1'b1; ser_active <= 1'b0; ser_st <= 0;
                end else ser_cnt <= ser_cnt + 1;
            endcase
        end
    end

    assign bus_a.i_tx_active = ser_active | ext_active;
    assign bus_a.i_tx_done   = ser_done;

    // Line decoder samples mid-bit and reports each received byte with its stop bit.
    int         dst = 0;
    int         dcnt = 0;
    int         dbit = 0;
    logic [7:0] dsh = '0;
    logic       line_evt = 1'b0;
    logic       line_stop = 1'b0;
    logic [7:0] line_byte = '0;

    always @(posedge clk) begin
        if (model_rst) begin
            dst <= 0; dcnt <= 0; line_evt <= 1'b0;
        end else begin
            line_evt <= 1'b0;
            case (dst)
                0: if (!ser_line) begin dst <= 1; dcnt <= 0; end
                1: if (dcnt == CPB / 2) begin
                    dcnt <= 0; dbit <= 0; dst <= ser_line ? 0 : 2;
                end else dcnt <= dcnt + 1;
                2: if (dcnt == CPB - 1) begin
                    dcnt <= 0; dsh <= {ser_line, dsh[7:1]};
                    if (dbit == 7) dst <= 3; else dbit <= dbit + 1;
                end else dcnt <= dcnt + 1;
                default: if (dcnt == CPB - 1) begin
                    dcnt <= 0; dst <= 0; line_evt <= 1'b1; line_byte <= dsh; line_stop <= ser_line;
                end else dcnt <= dcnt + 1;
            endcase
        end
    end

    // Hung serializer: busy for 40 cycles after a launch, never signals done.
    int hang_cnt = 0;
    always @(posedge clk) begin
        if (model_rst) hang_cnt <= 0;
        else if (bus_b.o_tx_dv) hang_cnt <= 40;
        else if (hang_cnt != 0) hang_cnt <= hang_cnt - 1;
    end
    assign bus_b.i_tx_active = (hang_cnt != 0);
    assign bus_b.i_tx_done   = 1'b0;

    typedef struct {
        int         kind;
        int         inst;
        logic [7:0] vec;
        logic [7:0] data;
        int         owner;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   last_done[2] = '{-1, -1};

    function automatic string kname(input int k);
        case (k)
            K_ACK:   return "ack";
            K_LINE:  return "line";
            K_DONE:  return "done";
            default: return "err";
        endcase
    endfunction

    task automatic expect_evt(input int kind, input int inst, input logic [7:0] vec,
                              input logic [7:0] data, input int owner, input int at);
        exp_t e;
        e.kind = kind; e.inst = inst; e.vec = vec; e.data = data; e.owner = owner; e.at = at;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int inst, input logic [7:0] vec,
                           input logic [7:0] data, input int owner, input bit flag);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s inst%0d: got vec=%b data=%h owner=%0d cycle=%0d, required no event",
                     kname(kind), inst, vec, data, owner, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.inst != inst || e.vec != vec || e.data != data ||
            e.owner != owner || !flag || (e.at >= 0 && e.at != cyc)) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %s vec=%b data=%h owner=%0d flag=%0d cycle=%0d, required %s inst%0d vec=%b data=%h owner=%0d flag=1 cycle=%0d",
                     kname(kind), inst, kname(kind), vec, data, owner, flag, cyc,
                     kname(e.kind), e.inst, e.vec, e.data, e.owner, e.at);
        end
    endtask

    task automatic gap_check(input int inst);
        if (last_done[inst] >= 0) begin
            vectors++;
            if (cyc - last_done[inst] < 2) begin
                miscompares++;
                $display("FAIL gap inst%0d: got %0d cycles from done to ack, required >= 2",
                         inst, cyc - last_done[inst]);
            end
        end
    endtask

    // Monitor: every output event is matched in order against the scoreboard queue.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_done[0] = -1;
            last_done[1] = -1;
        end
        if (bus_a.o_req_ack != '0 || bus_a.o_tx_dv) begin
            gap_check(0);
            observe(K_ACK, 0, {4'b0, bus_a.o_req_ack}, bus_a.o_tx_byte, int'(bus_a.o_owner), bus_a.o_tx_dv);
        end
        if (line_evt) observe(K_LINE, 0, 8'h00, line_byte, 0, line_stop);
        if (bus_a.o_req_done != '0) begin
            last_done[0] = cyc;
            observe(K_DONE, 0, {4'b0, bus_a.o_req_done}, 8'h00, int'(bus_a.o_owner), 1'b1);
        end
        if (bus_a.o_err) observe(K_ERR, 0, 8'h00, 8'h00, int'(bus_a.o_owner), 1'b1);
        if (bus_b.o_req_ack != '0 || bus_b.o_tx_dv) begin
            gap_check(1);
            observe(K_ACK, 1, {4'b0, bus_b.o_req_ack}, bus_b.o_tx_byte, int'(bus_b.o_owner), bus_b.o_tx_dv);
        end
        if (bus_b.o_req_done != '0) begin
            last_done[1] = cyc;
            observe(K_DONE, 1, {4'b0, bus_b.o_req_done}, 8'h00, int'(bus_b.o_owner), 1'b1);
        end
        if (bus_b.o_err) observe(K_ERR, 1, 8'h00, 8'h00, int'(bus_b.o_owner), 1'b1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Requesters hold valid until they see their own ack.
    task automatic tick();
        @(negedge clk);
        bus_a.i_req_valid = bus_a.i_req_valid & ~bus_a.o_req_ack;
        bus_b.i_req_valid = bus_b.i_req_valid & ~bus_b.o_req_ack;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((bus_a.i_req_valid != '0 || bus_b.i_req_valid != '0 || bus_a.o_busy ||
                bus_b.o_busy || ser_st != 0 || hang_cnt != 0) && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (k >= budget) begin
            miscompares++;
            $display("FAIL %s_timeout: got still busy after %0d cycles, required idle", name, budget);
        end
        run(3);
    endtask

    task automatic do_reset();
        bus_a.i_req_valid = '0;
        bus_b.i_req_valid = '0;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(1);
    endtask

    initial begin
        int c;
        bus_a.i_req_valid = '0; bus_a.i_req_byte = '0;
        bus_b.i_req_valid = '0; bus_b.i_req_byte = '0;
        run(3);
        model_rst = 1'b0;
        rst = 1'b0;
        run(2);

        chk("rst_ack",   int'(bus_a.o_req_ack), 0);
        chk("rst_done",  int'(bus_a.o_req_done), 0);
        chk("rst_dv",    int'(bus_a.o_tx_dv), 0);
        chk("rst_byte",  int'(bus_a.o_tx_byte), 0);
        chk("rst_busy",  int'(bus_a.o_busy), 0);
        chk("rst_err",   int'(bus_a.o_err), 0);
        chk("rst_owner", int'(bus_a.o_owner), 3);

        // Single byte from requester 2.
        bus_a.i_req_byte = 32'h0037_0000;
        bus_a.i_req_valid = 4'b0100;
        c = cyc;
        expect_evt(K_ACK, 0, 8'b0100, 8'h37, 2, c + 1);
        expect_evt(K_LINE, 0, 8'h00, 8'h37, 0, -1);
        expect_evt(K_DONE, 0, 8'b0100, 8'h00, 2, c + 2173);
        wait_idle("single", 3000);

        // All four pending: strict rotation, GAP between bytes.
        do_reset();
        bus_a.i_req_byte = 32'h1312_1110;
        bus_a.i_req_valid = 4'b1111;
        c = cyc;
        for (int n = 0; n < 4; n++) begin
            expect_evt(K_ACK, 0, 8'(1 << n), 8'(8'h10 + n), n, c + 1 + n * 2174);
            expect_evt(K_LINE, 0, 8'h00, 8'(8'h10 + n), 0, -1);
            expect_evt(K_DONE, 0, 8'(1 << n), 8'h00, n, c + 2173 + n * 2174);
        end
        wait_idle("rotate", 10000);

        // Requester 1 served, then 1 and 3 together: 3 goes first.
        bus_a.i_req_byte = 32'h0000_2100;
        bus_a.i_req_valid = 4'b0010;
        c = cyc;
        expect_evt(K_ACK, 0, 8'b0010, 8'h21, 1, c + 1);
        expect_evt(K_LINE, 0, 8'h00, 8'h21, 0, -1);
        expect_evt(K_DONE, 0, 8'b0010, 8'h00, 1, c + 2173);
        wait_idle("serve1", 3000);
        bus_a.i_req_byte = 32'h4300_4100;
        bus_a.i_req_valid = 4'b1010;
        c = cyc;
        expect_evt(K_ACK, 0, 8'b1000, 8'h43, 3, c + 1);
        expect_evt(K_LINE, 0, 8'h00, 8'h43, 0, -1);
        expect_evt(K_DONE, 0, 8'b1000, 8'h00, 3, c + 2173);
        expect_evt(K_ACK, 0, 8'b0010, 8'h41, 1, c + 2175);
        expect_evt(K_LINE, 0, 8'h00, 8'h41, 0, -1);
        expect_evt(K_DONE, 0, 8'b0010, 8'h00, 1, c + 4347);
        wait_idle("fair", 6000);

        // Hung serializer, timeout 50: err only, then the next request is served.
        do_reset();
        bus_b.i_req_byte = 32'h0000_5AA5;
        bus_b.i_req_valid = 4'b0011;
        c = cyc;
        expect_evt(K_ACK, 1, 8'b0001, 8'hA5, 0, c + 1);
        expect_evt(K_ERR, 1, 8'h00, 8'h00, 0, c + 51);
        expect_evt(K_ACK, 1, 8'b0010, 8'h5A, 1, c + 53);
        expect_evt(K_ERR, 1, 8'h00, 8'h00, 1, c + 103);
        wait_idle("timeout", 400);

        // Reset 500 cycles into a byte; the serializer finishes on its own.
        do_reset();
        bus_a.i_req_byte = 32'h00C3_0000;
        bus_a.i_req_valid = 4'b0100;
        c = cyc;
        expect_evt(K_ACK, 0, 8'b0100, 8'hC3, 2, c + 1);
        expect_evt(K_LINE, 0, 8'h00, 8'hC3, 0, -1);
        run(500);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy",  int'(bus_a.o_busy), 0);
        chk("midrst_dv",    int'(bus_a.o_tx_dv), 0);
        chk("midrst_owner", int'(bus_a.o_owner), 3);
        chk("midrst_ack",   int'(bus_a.o_req_ack), 0);
        bus_a.i_req_byte = 32'h3300_0030;
        bus_a.i_req_valid = 4'b1001;
        expect_evt(K_ACK, 0, 8'b0001, 8'h30, 0, -1);
        expect_evt(K_LINE, 0, 8'h00, 8'h30, 0, -1);
        expect_evt(K_DONE, 0, 8'b0001, 8'h00, 0, -1);
        expect_evt(K_ACK, 0, 8'b1000, 8'h33, 3, -1);
        expect_evt(K_LINE, 0, 8'h00, 8'h33, 0, -1);
        expect_evt(K_DONE, 0, 8'b1000, 8'h00, 3, -1);
        wait_idle("midrst", 8000);

        // Serializer reported busy externally: no grant until it drops.
        do_reset();
        ext_active = 1'b1;
        bus_a.i_req_byte = 32'h0000_0066;
        bus_a.i_req_valid = 4'b0001;
        run(20);
        chk("blocked_busy", int'(bus_a.o_busy), 0);
        chk("blocked_valid", int'(bus_a.i_req_valid), 1);
        ext_active = 1'b0;
        c = cyc;
        expect_evt(K_ACK, 0, 8'b0001, 8'h66, 0, c + 1);
        expect_evt(K_LINE, 0, 8'h00, 8'h66, 0, -1);
        expect_evt(K_DONE, 0, 8'b0001, 8'h00, 0, c + 2173);
        wait_idle("blocked", 3000);

        run(5);
        chk("sb_leftover", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #(40 * 60000);
        miscompares++;
        $display("FAIL watchdog: got simulation still running at cycle %0d, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end
endmodule
